// File: rtl/mul_seq.sv
// Sequential 32x32 unsigned multiplier: radix-2 shift-add over 32 cycles with a
// single carry-lookahead adder, IDLE/CALC/DONE handshake with start/ack.

module cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  logic [31:0] p_s;
  logic [31:0] g_s;
  logic [8:0]  cg_s;

  // Carries into each bit of a 4-bit group, fully looked-ahead from the group carry-in.
  function automatic logic [3:0] grp_carry(input logic [3:0] p, input logic [3:0] g,
                                           input logic c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  function automatic logic grp_gen(input logic [3:0] p, input logic [3:0] g);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  assign p_s = a ^ b;
  assign g_s = a & b;

  // Group-level lookahead chain across the eight 4-bit groups.
  always_comb begin
    cg_s    = 9'd0;
    s       = 32'd0;
    cg_s[0] = ci;
    for (int k = 0; k < 8; k++) begin
      cg_s[k+1]  = grp_gen(p_s[4*k +: 4], g_s[4*k +: 4]) | ((&p_s[4*k +: 4]) & cg_s[k]);
      s[4*k +: 4] = p_s[4*k +: 4] ^ grp_carry(p_s[4*k +: 4], g_s[4*k +: 4], cg_s[k]);
    end
    co = cg_s[8];
  end

endmodule

module mul_seq #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ack,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q;
  logic [W-1:0] mcand_q;
  logic [W-1:0] acc_q;
  logic [W-1:0] mplr_q;
  logic [4:0]   cnt_q;
  logic         busy_q;
  logic         done_q;
  logic [W-1:0] hi_q;
  logic [W-1:0] lo_q;

  logic [W-1:0] cla_s;
  logic         cla_co_s;
  logic [W:0]   sum_s;
  logic [W-1:0] acc_d;
  logic [W-1:0] mplr_d;

  cla32 u_cla (
    .a  (acc_q),
    .b  (mcand_q),
    .ci (1'b0),
    .s  (cla_s),
    .co (cla_co_s)
  );

  // Partial sum {acc_c,acc}, then shift {acc_c,acc,mplr} right; the carry lands in acc[W-1].
  always_comb begin
    sum_s = {1'b0, acc_q};
    if (mplr_q[0]) begin
      sum_s = {cla_co_s, cla_s};
    end else begin
      sum_s = {1'b0, acc_q};
    end
    acc_d  = sum_s[W:1];
    mplr_d = {sum_s[0], mplr_q[W-1:1]};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mcand_q <= {W{1'b0}};
      acc_q   <= {W{1'b0}};
      mplr_q  <= {W{1'b0}};
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= {W{1'b0}};
      lo_q    <= {W{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= CALC;
            mcand_q <= a;
            acc_q   <= {W{1'b0}};
            mplr_q  <= b;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          acc_q  <= acc_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            hi_q    <= acc_d;
            lo_q    <= mplr_d;
          end
        end
        DONE: begin
          // start arriving with ack is dropped; a new request needs a later IDLE edge
          if (ack) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: stimulus pushes expected products, a monitor
// pops and checks value and 32-cycle latency on every rising done.

module tb_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic done_prev = 1'b0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  mul_seq #(.W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ack   (ack),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every rising edge of done must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no result pending");
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_hi", {32'd0, hi}, {32'd0, e.hi});
        check("result_lo", {32'd0, lo}, {32'd0, e.lo});
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    done_prev <= done;
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    e.hi = eh;
    e.lo = el;
    e.cyc = cyc + 1 + 32;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 45) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 45 cycles");
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    check("ack_done", {63'd0, done}, 64'd0);
    check("ack_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic run(input logic [31:0] av, input logic [31:0] bv,
                     input logic [31:0] eh, input logic [31:0] el);
    issue(av, bv, eh, el);
    wait_done();
    do_ack();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // ack outside DONE must do nothing
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    check("idle_ack_busy", {63'd0, busy}, 64'd0);

    issue(32'd3, 32'd5, 32'h0, 32'hF);
    #1 check("calc_busy", {62'd0, busy, done}, 64'd2);
    wait_done();
    do_ack();

    run(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run(32'h0000FFFF, 32'h00010001, 32'h00000000, 32'hFFFFFFFF);
    run(32'h89ABCDEF, 32'h00000010, 32'h00000008, 32'h9ABCDEF0);
    run(32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000);

    // zero multiplier: previous result stays visible during CALC
    issue(32'h12345678, 32'h0, 32'h0, 32'h0);
    repeat (5) @(negedge clk);
    check("prev_hi_held", {32'd0, hi}, 64'h1);
    check("prev_lo_held", {32'd0, lo}, 64'h0);
    wait_done();
    do_ack();

    // second start at CALC cycle 10 is ignored
    issue(32'd7, 32'd9, 32'h0, 32'h3F);
    repeat (9) @(posedge clk);
    @(negedge clk);
    a = 32'd2;
    b = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();
    do_ack();

    // async reset mid-CALC aborts with no result
    @(negedge clk);
    a = 32'hDEADBEEF;
    b = 32'h0000BEEF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    check("async_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_done", {63'd0, done}, 64'd0);

    // 6*7, hold DONE five cycles without ack
    issue(32'd6, 32'd7, 32'h0, 32'd42);
    wait_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_done", {63'd0, done}, 64'd1);
      check("hold_hilo", {hi, lo}, 64'd42);
    end

    // ack and start together: back to IDLE, new request dropped
    @(negedge clk);
    a = 32'd1;
    b = 32'd1;
    ack = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    start = 1'b0;
    check("ackstart_busy", {63'd0, busy}, 64'd0);
    repeat (3) @(negedge clk);
    check("ackstart_no_op", {62'd0, busy, done}, 64'd0);
    check("ackstart_hilo", {hi, lo}, 64'd42);

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
